seven_seg_scan_n: RTL
=====================

# seven_seg_scan_n

Parametrised multi-digit seven-segment scanner, next generation of the team's 4-digit BCD display driver. Generates its own refresh timing from the system clock, supports N digits, per-digit enable, decimal points, PWM brightness, anti-ghosting dead time and tear-free frame-synchronous updates. Sits between the board-level display pins and any block producing packed BCD values (counters, speed/distance readouts).

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..16)
- SLOT_CYCLES, 40000, clk cycles per digit slot; 40000 gives 2.5 kHz digit rate at 100 MHz; must be a multiple of 2**DUTY_BITS
- DUTY_BITS, 4, brightness resolution in bits
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- digits  in  4*NUM_DIGITS  packed BCD; digit i = digits[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark, slot still consumed
- update  in  1  one-cycle strobe: capture digits/dp_in into pending register
- brightness  in  DUTY_BITS  on-time level; 0 = dimmest, all-ones = full
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- anode  out  NUM_DIGITS  digit select, active low, at most one bit low
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot

## Operation
- Slot counter cyc runs 0..SLOT_CYCLES-1; at wrap, digit index idx increments modulo NUM_DIGITS.
- Sub-phase: ph = cyc / (SLOT_CYCLES >> DUTY_BITS), range 0..2**DUTY_BITS-1.
- brightness sampled into bri_q at cyc == 0 of every slot; changes mid-slot have no effect until the next slot.
- Anode for idx is low iff cyc != 0 (dead-time cycle), ph <= bri_q and digit_en[idx]; all others high.
- Decode: 0..9 standard active-low patterns (0 = 7'b1000000, 8 = 7'b0000000); 10..15 = 7'b1111111 (blank).
- Double buffering: update captures digits/dp_in into pending and sets pending_valid; at frame wrap (idx NUM_DIGITS-1 -> 0) pending copies into display register and pending_valid clears. Display never changes mid-frame.
- update coinciding with frame wrap: new data captured into pending; it is displayed at the following wrap, not the current one.
- Multiple updates within one frame: last one wins.

## Timing
- Reset values: seg 7'h7F, dp 1, anode all ones, frame_done 0; cyc, idx, bri_q, display, pending, pending_valid all 0.
- Reset is asynchronous; asserting mid-slot forces outputs to reset values immediately; scanning restarts at idx 0, cyc 0 on the first edge after release.
- All outputs registered: values computed for cycle cyc appear one clk after that cycle; seg, dp and anode always change on the same edge.
- Lit cycles per slot = (bri_q+1)*SLOT_CYCLES/2**DUTY_BITS - 1.
- frame_done period = NUM_DIGITS*SLOT_CYCLES cycles.
- Display latency of update: display register loads at the next frame wrap (at most one frame); seen on outputs one clk later.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking; display-register digits above the most significant non-zero digit show seg 7'h7F (dp unaffected); digit 0 is never blanked, so all-zero shows a single "0".
- Undefined: every digit decoded as-is; zeros shown.

## Structure
- Shared package seven_seg_pkg: segment pattern constants (SEG_0..SEG_9, SEG_BLANK), active-low polarity constant, decode function for BCD-to-segments.
- One sub-module: seven_seg_decode (combinational BCD-to-segment with blank), instantiated once on the selected digit.
- Scan counter, PWM compare, buffering and optional LZB logic stay in the top module.

## Test plan
Bench parameters NUM_DIGITS=4, SLOT_CYCLES=16, DUTY_BITS=2 (4-cycle sub-phase).
- Reset release, digits=16'h1234, update, brightness=3, digit_en=4'hF -> after next frame_done: anode 1110 for 15 of 16 cycles with seg 7'b0011001 (4), then 1101 with 7'b0110000 (3); dead cycle anode 1111.
- brightness=0 -> each slot lit exactly 3 cycles (cyc 1..3); brightness changed at cyc 5 -> applies from next slot only.
- update with 16'h5678 at cyc 8 of idx 1 -> outputs keep 1234 until frame wrap, then 5678; no mixed frame.
- digit_en=4'b0101, digits=16'h0A09, dp_in=4'b0001 -> digit 1 and 3 anodes never low; digit 2 seg 7'h7F; digit 0 seg 7'b0010000, dp 0.
- With SEVSEG_LZB_EN, digits=16'h0005 -> digits 3..1 seg 7'h7F, digit 0 shows 5; digits=16'h0000 -> only digit 0 shows 0; without macro -> all show 0.
- rst asserted at cyc 7 of idx 2 -> same-cycle seg 7'h7F, anode 1111, frame_done 0; after release scan starts at idx 0, display cleared to zeros.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared segment constants and BCD-to-segment decode for the seven-segment scanner.
// Patterns are {g,f,e,d,c,b,a}, active low.
package seven_seg_pkg;

    localparam logic SEG_ACTIVE = 1'b0;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD-to-segment decoder; blank_i forces all segments off.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_decode(bcd_i);

endmodule

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment scanner with PWM brightness, dead time and
// frame-synchronous double buffering. SEVSEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan_n
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 40000,
    parameter int DUTY_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    update,
    input  logic [DUTY_BITS-1:0]    brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int SUB = SLOT_CYCLES >> DUTY_BITS;
    localparam int CW  = $clog2(SLOT_CYCLES);
    localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]                  cyc_q, cyc_d;
    logic [SW-1:0]                  sub_q, sub_d;
    logic [DUTY_BITS-1:0]           ph_q, ph_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [DUTY_BITS-1:0]           bri_q, bri_d;
    logic [NUM_DIGITS-1:0][3:0]     disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]          disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                           pend_vld_q, pend_vld_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic [NUM_DIGITS-1:0]          anode_q, anode_d;
    logic                           fdone_q, fdone_d;

    logic slot_end, frame_end, sub_end, lit, blank_sel;
    logic [6:0] dec_seg;

`ifdef SEVSEG_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_blank;
    logic                  zero_run;

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lzb_blank = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run     = zero_run & (disp_q[i] == 4'd0);
            lzb_blank[i] = zero_run;
        end
    end
    assign blank_sel = lzb_blank[idx_q];
`else
    assign blank_sel = 1'b0;
`endif

    seven_seg_decode u_dec (
        .bcd_i   (disp_q[idx_q]),
        .blank_i (blank_sel),
        .seg_o   (dec_seg)
    );

    always_comb begin
        slot_end  = (cyc_q == CW'(SLOT_CYCLES - 1));
        frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        sub_end   = (sub_q == SW'(SUB - 1));

        cyc_d = slot_end ? '0 : cyc_q + 1'b1;
        sub_d = (slot_end || sub_end) ? '0 : sub_q + 1'b1;
        ph_d  = slot_end ? '0 : (sub_end ? ph_q + 1'b1 : ph_q);
        idx_d = slot_end ? (frame_end ? '0 : idx_q + 1'b1) : idx_q;
        bri_d = (cyc_q == '0) ? brightness : bri_q;

        // Pending loads on any update; the display only takes it at frame wrap,
        // so an update on the wrap cycle itself waits for the following wrap.
        pend_d     = update ? digits : pend_q;
        pend_dp_d  = update ? dp_in  : pend_dp_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_vld_d = pend_vld_q | update;
        if (frame_end) begin
            if (pend_vld_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
            pend_vld_d = update;
        end

        lit     = (cyc_q != '0) && (ph_q <= bri_q) && digit_en[idx_q];
        anode_d = {NUM_DIGITS{~SEG_ACTIVE}};
        if (lit) anode_d[idx_q] = SEG_ACTIVE;
        seg_d   = dec_seg;
        dp_d    = disp_dp_q[idx_q] ? SEG_ACTIVE : ~SEG_ACTIVE;
        fdone_d = frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q      <= '0;
            sub_q      <= '0;
            ph_q       <= '0;
            idx_q      <= '0;
            bri_q      <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            anode_q    <= '1;
            fdone_q    <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            sub_q      <= sub_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            bri_q      <= bri_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
            fdone_q    <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign frame_done = fdone_q;

endmodule
